csr_file: RTL and testbench

Machine-mode CSR register file for the milano core. It is the responder for both CSR write streams: the EX-stage CSR instructions (CSRRW/S/C results) and the trap controller's save-site/MRET writes. It provides the combinational CSR read data for EX and the live mstatus/mepc/mtvec/mie/mip values that drive the trap controller. It also latches interrupt pending bits and runs the cycle/instret counters.

---
 rtl/milano_pkg.sv | 36 +++
 rtl/csr_counter64.sv | 18 +
 rtl/csr_file.sv | 111 +++++++++++
 tb/tb_csr_file.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/milano_pkg.sv
// milano_pkg: CSR addresses, WARL masks and write-port helpers shared by the milano CSR file.
package milano_pkg;
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;
  localparam logic [31:0] MSTATUS_WMASK = 32'h88;
  localparam logic [31:0] MIE_WMASK     = 32'h88;
  localparam logic [31:0] MSTATUS_RO    = 32'h1800;
  localparam logic [31:0] ALIGN4_MASK   = 32'hFFFF_FFFC;
  typedef struct packed {
    logic        we;
    logic [11:0] addr;
    logic [31:0] data;
  } csr_wr_t;
  function automatic logic hit(csr_wr_t w, logic [11:0] a);
    return w.we && (w.addr == a);
  endfunction
  function automatic logic wr_en(csr_wr_t c, csr_wr_t e, logic [11:0] a);
    return hit(c, a) || hit(e, a);
  endfunction
  // ctrl wins when both ports target the same address
  function automatic logic [31:0] wr_val(csr_wr_t c, csr_wr_t e, logic [11:0] a);
    return hit(c, a) ? c.data : e.data;
  endfunction
endpackage

// File: rtl/csr_counter64.sv
// csr_counter64: 64-bit counter with independently writable halves; a write suppresses the increment.
module csr_counter64 (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        inc_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [63:0] wdata_i,
  output logic [63:0] cnt_o
);
  logic [63:0] r_cnt;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) r_cnt <= '0;
    else if (wr_lo_i || wr_hi_i) r_cnt <= {wr_hi_i ? wdata_i[63:32] : r_cnt[63:32],
                                           wr_lo_i ? wdata_i[31:0]  : r_cnt[31:0]};
    else if (inc_i) r_cnt <= r_cnt + 64'd1;
  assign cnt_o = r_cnt;
endmodule

// File: rtl/csr_file.sv
// csr_file: milano machine-mode CSR file with dual write ports and combinational EX read.
// Define CSR_COUNTERS_EN to build the mcycle/minstret counters.
module csr_file
  import milano_pkg::*;
#(
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000,
  parameter logic [31:0] MISA_VAL  = 32'h4000_1100
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [11:0] ex_csr_raddr_i,
  output logic [31:0] ex_csr_rdata_o,
  output logic        ex_csr_illegal_o,
  input  logic        ex_csr_we_i,
  input  logic [11:0] ex_csr_waddr_i,
  input  logic [31:0] ex_csr_wdata_i,
  input  logic        ctrl_csr_we_i,
  input  logic [11:0] ctrl_csr_waddr_i,
  input  logic [31:0] ctrl_csr_wdata_i,
  input  logic        timer_irq_i,
  input  logic        sw_irq_i,
  input  logic        instr_retire_i,
  output logic [31:0] csr_mstatus_o,
  output logic [31:0] csr_mepc_o,
  output logic [31:0] csr_mtvec_o,
  output logic [31:0] csr_mie_o,
  output logic [31:0] csr_mip_o
);
  csr_wr_t w_ex, w_ctrl;
  logic [31:0] r_mstatus, r_mie, r_mtvec, r_mscratch, r_mepc, r_mcause, r_mtval, r_mip;
  logic [31:0] w_rdata;
  logic        w_illegal;
  assign w_ex   = '{we: ex_csr_we_i,   addr: ex_csr_waddr_i,   data: ex_csr_wdata_i};
  assign w_ctrl = '{we: ctrl_csr_we_i, addr: ctrl_csr_waddr_i, data: ctrl_csr_wdata_i};
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      r_mstatus  <= '0;
      r_mie      <= '0;
      r_mtvec    <= MTVEC_RST & ALIGN4_MASK;
      r_mscratch <= '0;
      r_mepc     <= '0;
      r_mcause   <= '0;
      r_mtval    <= '0;
      r_mip      <= '0;
    end else begin
      if (wr_en(w_ctrl, w_ex, CSR_MSTATUS))  r_mstatus  <= wr_val(w_ctrl, w_ex, CSR_MSTATUS) & MSTATUS_WMASK;
      if (wr_en(w_ctrl, w_ex, CSR_MIE))      r_mie      <= wr_val(w_ctrl, w_ex, CSR_MIE) & MIE_WMASK;
      if (wr_en(w_ctrl, w_ex, CSR_MTVEC))    r_mtvec    <= wr_val(w_ctrl, w_ex, CSR_MTVEC) & ALIGN4_MASK;
      if (wr_en(w_ctrl, w_ex, CSR_MSCRATCH)) r_mscratch <= wr_val(w_ctrl, w_ex, CSR_MSCRATCH);
      if (wr_en(w_ctrl, w_ex, CSR_MEPC))     r_mepc     <= wr_val(w_ctrl, w_ex, CSR_MEPC) & ALIGN4_MASK;
      if (wr_en(w_ctrl, w_ex, CSR_MCAUSE))   r_mcause   <= wr_val(w_ctrl, w_ex, CSR_MCAUSE);
      if (wr_en(w_ctrl, w_ex, CSR_MTVAL))    r_mtval    <= wr_val(w_ctrl, w_ex, CSR_MTVAL);
      r_mip <= {24'b0, timer_irq_i, 3'b0, sw_irq_i, 3'b0};
    end
`ifdef CSR_COUNTERS_EN
  logic [63:0] w_mcycle, w_minstret;
  csr_counter64 u_mcycle (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc_i   (1'b1),
    .wr_lo_i (wr_en(w_ctrl, w_ex, CSR_MCYCLE)),
    .wr_hi_i (wr_en(w_ctrl, w_ex, CSR_MCYCLEH)),
    .wdata_i ({wr_val(w_ctrl, w_ex, CSR_MCYCLEH), wr_val(w_ctrl, w_ex, CSR_MCYCLE)}),
    .cnt_o   (w_mcycle)
  );
  csr_counter64 u_minstret (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc_i   (instr_retire_i),
    .wr_lo_i (wr_en(w_ctrl, w_ex, CSR_MINSTRET)),
    .wr_hi_i (wr_en(w_ctrl, w_ex, CSR_MINSTRETH)),
    .wdata_i ({wr_val(w_ctrl, w_ex, CSR_MINSTRETH), wr_val(w_ctrl, w_ex, CSR_MINSTRET)}),
    .cnt_o   (w_minstret)
  );
`else
  logic w_unused;
  assign w_unused = instr_retire_i;
`endif
  always_comb begin
    w_rdata   = '0;
    w_illegal = 1'b0;
    case (ex_csr_raddr_i)
      CSR_MSTATUS:  w_rdata = csr_mstatus_o;
      CSR_MISA:     w_rdata = MISA_VAL;
      CSR_MIE:      w_rdata = r_mie;
      CSR_MTVEC:    w_rdata = r_mtvec;
      CSR_MSCRATCH: w_rdata = r_mscratch;
      CSR_MEPC:     w_rdata = r_mepc;
      CSR_MCAUSE:   w_rdata = r_mcause;
      CSR_MTVAL:    w_rdata = r_mtval;
      CSR_MIP:      w_rdata = r_mip;
      CSR_MHARTID:  w_rdata = '0;
`ifdef CSR_COUNTERS_EN
      CSR_MCYCLE:    w_rdata = w_mcycle[31:0];
      CSR_MCYCLEH:   w_rdata = w_mcycle[63:32];
      CSR_MINSTRET:  w_rdata = w_minstret[31:0];
      CSR_MINSTRETH: w_rdata = w_minstret[63:32];
`else
      CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH: w_rdata = '0;
`endif
      default:      w_illegal = 1'b1;
    endcase
  end
  assign ex_csr_rdata_o   = w_rdata;
  assign ex_csr_illegal_o = w_illegal;
  assign csr_mstatus_o    = r_mstatus | MSTATUS_RO;
  assign csr_mepc_o       = r_mepc;
  assign csr_mtvec_o      = r_mtvec;
  assign csr_mie_o        = r_mie;
  assign csr_mip_o        = r_mip;
endmodule

// File: tb/tb_csr_file.sv
// tb_csr_file: randomized and directed checks of csr_file against a behavioural CSR model.
module tb_csr_file;
  logic        clk = 1'b0;
  logic        rst_ni;
  logic [11:0] raddr;
  logic [31:0] rdata;
  logic        illegal;
  logic        ex_we, ctrl_we;
  logic [11:0] ex_addr, ctrl_addr;
  logic [31:0] ex_data, ctrl_data;
  logic        timer_irq, sw_irq, retire;
  logic [31:0] o_mstatus, o_mepc, o_mtvec, o_mie, o_mip;
  int n_vec = 0;
  int n_bad = 0;
`ifdef CSR_COUNTERS_EN
  localparam bit CNT = 1'b1;
`else
  localparam bit CNT = 1'b0;
`endif
  always #5 clk = ~clk;
  csr_file dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .ex_csr_raddr_i(raddr), .ex_csr_rdata_o(rdata), .ex_csr_illegal_o(illegal),
    .ex_csr_we_i(ex_we), .ex_csr_waddr_i(ex_addr), .ex_csr_wdata_i(ex_data),
    .ctrl_csr_we_i(ctrl_we), .ctrl_csr_waddr_i(ctrl_addr), .ctrl_csr_wdata_i(ctrl_data),
    .timer_irq_i(timer_irq), .sw_irq_i(sw_irq), .instr_retire_i(retire),
    .csr_mstatus_o(o_mstatus), .csr_mepc_o(o_mepc), .csr_mtvec_o(o_mtvec),
    .csr_mie_o(o_mie), .csr_mip_o(o_mip)
  );
  // Architectural view of every CSR as a reader would see it
  logic [31:0] e_mstatus, e_mie, e_mtvec, e_mscratch, e_mepc, e_mcause, e_mtval, e_mip;
  logic [63:0] e_cyc, e_ins;
  logic [11:0] addrs [16] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                              12'h344, 12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'hF14, 12'h7C0, 12'h302};
  function void m_reset();
    e_mstatus = 32'h1800; e_mie = 0; e_mtvec = 0; e_mscratch = 0;
    e_mepc = 0; e_mcause = 0; e_mtval = 0; e_mip = 0; e_cyc = 0; e_ins = 0;
  endfunction
  function automatic logic [31:0] m_read(logic [11:0] a, output bit ill);
    ill = 1'b0;
    case (a)
      12'h300: return e_mstatus;
      12'h301: return 32'h4000_1100;
      12'h304: return e_mie;
      12'h305: return e_mtvec;
      12'h340: return e_mscratch;
      12'h341: return e_mepc;
      12'h342: return e_mcause;
      12'h343: return e_mtval;
      12'h344: return e_mip;
      12'hF14: return 32'h0;
      12'hB00: return CNT ? e_cyc[31:0] : 32'h0;
      12'hB80: return CNT ? e_cyc[63:32] : 32'h0;
      12'hB02: return CNT ? e_ins[31:0] : 32'h0;
      12'hB82: return CNT ? e_ins[63:32] : 32'h0;
      default: begin ill = 1'b1; return 32'h0; end
    endcase
  endfunction
  function automatic void m_write(logic [11:0] a, logic [31:0] d, inout bit cw, inout bit iw);
    case (a)
      12'h300: e_mstatus = 32'h1800 | (d & 32'h88);
      12'h304: e_mie = d & 32'h88;
      12'h305: e_mtvec = {d[31:2], 2'b00};
      12'h340: e_mscratch = d;
      12'h341: e_mepc = {d[31:2], 2'b00};
      12'h342: e_mcause = d;
      12'h343: e_mtval = d;
      12'hB00: begin e_cyc[31:0] = d; cw = 1'b1; end
      12'hB80: begin e_cyc[63:32] = d; cw = 1'b1; end
      12'hB02: begin e_ins[31:0] = d; iw = 1'b1; end
      12'hB82: begin e_ins[63:32] = d; iw = 1'b1; end
      default: ;
    endcase
  endfunction
  // Advance one clock, updating the model from the inputs present at the edge
  task automatic step();
    bit cw, iw;
    #1;
    if (rst_ni) begin
      cw = 1'b0; iw = 1'b0;
      if (ctrl_we) m_write(ctrl_addr, ctrl_data, cw, iw);
      if (ex_we && !(ctrl_we && ctrl_addr == ex_addr)) m_write(ex_addr, ex_data, cw, iw);
      if (!cw) e_cyc = e_cyc + 1;
      if (!iw && retire) e_ins = e_ins + 1;
      e_mip = (32'(timer_irq) << 7) | (32'(sw_irq) << 3);
    end
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    ex_we = 0; ctrl_we = 0; retire = 0;
  endtask
  task automatic test_reset();
    bit ill;
    rst_ni = 0; raddr = 12'hB00; idle();
    ex_addr = 0; ex_data = 0; ctrl_addr = 0; ctrl_data = 0; timer_irq = 0; sw_irq = 0;
    m_reset();
    step(); step();
    n_vec++; if (o_mstatus !== 32'h1800) begin n_bad++; $display("FAIL rst_mstatus got %h exp %h", o_mstatus, 32'h1800); end
    n_vec++; if (o_mtvec !== 32'h0) begin n_bad++; $display("FAIL rst_mtvec got %h exp 0", o_mtvec); end
    n_vec++; if (o_mip !== 32'h0) begin n_bad++; $display("FAIL rst_mip got %h exp 0", o_mip); end
    n_vec++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL rst_mcycle got %h exp 0", rdata); end
    rst_ni = 1;
    step();
    n_vec++; if (rdata !== m_read(12'hB00, ill)) begin n_bad++; $display("FAIL mcycle_after_rst got %h exp %h", rdata, m_read(12'hB00, ill)); end
  endtask
  task automatic test_warl();
    logic [11:0] wa [3] = '{12'h300, 12'h305, 12'h304};
    for (int i = 0; i < 3; i++) begin
      ex_we = 1; ex_addr = wa[i]; ex_data = 32'hFFFF_FFFF; step();
    end
    idle(); ex_addr = 12'h344; ex_data = 32'h8; ex_we = 1; step(); idle();
    n_vec++; if (o_mstatus !== 32'h1888) begin n_bad++; $display("FAIL warl_mstatus got %h exp 1888", o_mstatus); end
    n_vec++; if (o_mtvec !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL warl_mtvec got %h exp fffffffc", o_mtvec); end
    n_vec++; if (o_mie !== 32'h88) begin n_bad++; $display("FAIL warl_mie got %h exp 88", o_mie); end
    n_vec++; if (o_mip !== 32'h0) begin n_bad++; $display("FAIL mip_ro got %h exp 0", o_mip); end
    raddr = 12'h301; #1;
    n_vec++; if (rdata !== 32'h4000_1100) begin n_bad++; $display("FAIL misa got %h exp 40001100", rdata); end
  endtask
  task automatic test_dual();
    ex_we = 1; ex_addr = 12'h341; ex_data = 32'h100;
    ctrl_we = 1; ctrl_addr = 12'h341; ctrl_data = 32'h204; step();
    n_vec++; if (o_mepc !== 32'h204) begin n_bad++; $display("FAIL dual_same got %h exp 204", o_mepc); end
    ex_data = 32'h300; ctrl_addr = 12'h342; ctrl_data = 32'h8000_0007; step(); idle();
    raddr = 12'h342; #1;
    n_vec++; if (o_mepc !== 32'h300) begin n_bad++; $display("FAIL dual_ex got %h exp 300", o_mepc); end
    n_vec++; if (rdata !== 32'h8000_0007) begin n_bad++; $display("FAIL dual_ctrl got %h exp 80000007", rdata); end
  endtask
  task automatic test_counters();
    bit ill;
    ex_we = 1; ex_addr = 12'hB00; ex_data = 32'hFFFF_FFFE; step(); idle();
    step(); step();
    raddr = 12'hB80; #1;
    n_vec++; if (rdata !== m_read(12'hB80, ill)) begin n_bad++; $display("FAIL mcycleh_carry got %h exp %h", rdata, m_read(12'hB80, ill)); end
    raddr = 12'hB00; #1;
    n_vec++; if (rdata !== m_read(12'hB00, ill)) begin n_bad++; $display("FAIL mcycle_wrap got %h exp %h", rdata, m_read(12'hB00, ill)); end
    for (int i = 0; i < 3; i++) begin retire = 1; step(); retire = 0; step(); end
    raddr = 12'hB02; #1;
    n_vec++; if (rdata !== m_read(12'hB02, ill)) begin n_bad++; $display("FAIL minstret got %h exp %h", rdata, m_read(12'hB02, ill)); end
  endtask
  task automatic test_irq();
    timer_irq = 1; step();
    n_vec++; if (o_mip !== 32'h80) begin n_bad++; $display("FAIL mip_timer got %h exp 80", o_mip); end
    timer_irq = 0; sw_irq = 1; step(); sw_irq = 0;
    n_vec++; if (o_mip !== 32'h08) begin n_bad++; $display("FAIL mip_sw got %h exp 08", o_mip); end
    raddr = 12'h7C0; #1;
    n_vec++; if (rdata !== 32'h0 || illegal !== 1'b1) begin n_bad++; $display("FAIL illegal got %h/%b exp 0/1", rdata, illegal); end
  endtask
  task automatic test_random();
    bit ill;
    logic [31:0] exp;
    for (int i = 0; i < 300; i++) begin
      ex_we = 1'($urandom); ex_addr = addrs[$urandom_range(15)]; ex_data = $urandom;
      ctrl_we = 1'($urandom); ctrl_addr = ($urandom_range(3) == 0) ? ex_addr : addrs[$urandom_range(15)];
      ctrl_data = $urandom; timer_irq = 1'($urandom); sw_irq = 1'($urandom); retire = 1'($urandom);
      raddr = ($urandom_range(1) == 0) ? ex_addr : addrs[$urandom_range(15)];
      #1;
      exp = m_read(raddr, ill);
      n_vec++; if (rdata !== exp || illegal !== ill) begin n_bad++; $display("FAIL rnd_read[%h] got %h/%b exp %h/%b", raddr, rdata, illegal, exp, ill); end
      step();
      n_vec++;
      if (o_mstatus !== e_mstatus || o_mepc !== e_mepc || o_mtvec !== e_mtvec || o_mie !== e_mie || o_mip !== e_mip) begin
        n_bad++;
        $display("FAIL rnd_outs got %h %h %h %h %h exp %h %h %h %h %h", o_mstatus, o_mepc, o_mtvec, o_mie, o_mip,
                 e_mstatus, e_mepc, e_mtvec, e_mie, e_mip);
      end
    end
    idle(); timer_irq = 0; sw_irq = 0;
  endtask
  task automatic test_reset_mid();
    bit ill;
    logic [11:0] seq [4] = '{12'h342, 12'h341, 12'h343, 12'h300};
    timer_irq = 1;
    for (int i = 0; i < 2; i++) begin ctrl_we = 1; ctrl_addr = seq[i]; ctrl_data = 32'hDEAD_BEEF; step(); end
    ctrl_addr = seq[2]; #2; rst_ni = 0; #1;
    n_vec++;
    if (o_mstatus !== 32'h1800 || o_mepc !== 0 || o_mtvec !== 0 || o_mie !== 0 || o_mip !== 0) begin
      n_bad++;
      $display("FAIL mid_rst got %h %h %h %h %h", o_mstatus, o_mepc, o_mtvec, o_mie, o_mip);
    end
    m_reset(); idle(); timer_irq = 0; step(); rst_ni = 1;
    ctrl_we = 1; ctrl_addr = seq[3]; ctrl_data = 32'h0000_0080; step(); idle();
    n_vec++; if (o_mstatus !== 32'h1880) begin n_bad++; $display("FAIL post_rst_mstatus got %h exp 1880", o_mstatus); end
    raddr = 12'h342; #1;
    n_vec++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL post_rst_mcause got %h exp 0", rdata); end
    raddr = 12'hB00; #1;
    n_vec++; if (rdata !== m_read(12'hB00, ill)) begin n_bad++; $display("FAIL post_rst_mcycle got %h exp %h", rdata, m_read(12'hB00, ill)); end
  endtask
  initial begin
    test_reset();
    test_warl();
    test_dual();
    test_counters();
    test_irq();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
